// File: rtl/nes_palette_loader.sv
`default_nettype none
// ============================================================================
//  Module      : nes_palette_loader
//  Description : Packs the HPS ioctl byte stream (R,G,B per entry) into 24-bit
//                palette entries, buffers them in a small FIFO, and writes
//                them into the video block's palette RAM only while
//                write_window is high (blanking).
//  Revision    : 1.0  initial release
// ============================================================================
module nes_palette_loader #(
  parameter int ENTRIES    = 64,  // entries accepted per download, at most 64
  parameter int FIFO_DEPTH = 2    // completed-entry buffer depth, power of two >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        write_window,
  output logic        load_color,
  output logic [23:0] load_color_data,
  output logic [5:0]  load_color_index,
  output logic        pal_loaded,
  output logic        busy,
  output logic        overrun
);

  localparam int c_ENTRY_W = $clog2(ENTRIES + 1);
  localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_ENTRY_W-1:0] c_ENTRIES  = c_ENTRY_W'(ENTRIES);
  localparam logic [c_CNT_W-1:0]   c_FULL     = c_CNT_W'(FIFO_DEPTH);
  localparam logic [5:0]           c_LAST_IDX = 6'(ENTRIES - 1);

  // Byte position within the current R,G,B triplet.
  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_t;

  // Download tracking. r_dl_prev resets high so that a download already in
  // progress when reset is released is not mistaken for a fresh start.
  logic                 r_dl_prev;
  logic                 r_active;

  // Triplet assembly.
  phase_t               r_phase;
  logic [7:0]           r_red;
  logic [7:0]           r_grn;
  logic [c_ENTRY_W-1:0] r_entry;

  // Completed-entry FIFO: each word is {R,G,B,index}.
  logic [29:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;

  // Registered outputs.
  logic                 r_load_color;
  logic [23:0]          r_lc_data;
  logic [5:0]           r_lc_index;
  logic                 r_pal_loaded;
  logic                 r_overrun;
  logic                 r_busy;

  // Combinational control.
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_wait;
  logic                 w_take;
  logic                 w_accept;
  logic                 w_overrun_ev;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_active_nxt;
  logic                 w_busy_nxt;
  phase_t               w_phase_eff;
  phase_t               w_phase_nxt;
  logic [c_CNT_W-1:0]   w_count_nxt;

  // Edge detection, byte qualification and push/pop decisions.
  always_comb begin
    w_rise = ioctl_download & ~r_dl_prev;
    w_fall = ~ioctl_download & r_dl_prev;
    w_wait = (r_count == c_FULL);

    // A start clears the phase before a same-cycle byte is assembled.
    w_phase_eff = w_rise ? PH_R : r_phase;

    // A byte belongs to this download only after a seen rising edge; a
    // download that survived a reset is ignored until it restarts.
    w_take = ioctl_wr & ioctl_download & (w_rise | r_active);

    // On the start cycle the FIFO is flushed, so backpressure from the old
    // contents does not apply to that byte.
    w_overrun_ev = w_take & ~w_rise & w_wait;
    w_accept     = w_take & (w_rise | (~w_wait & (r_entry != c_ENTRIES)));
    w_push       = w_accept & (w_phase_eff == PH_B);
    w_pop        = write_window & (r_count != '0) & ~w_rise;

    w_active_nxt = w_rise | (r_active & ~w_fall);
  end

  // Next triplet phase: advance per accepted byte, drop partials on end.
  always_comb begin
    w_phase_nxt = w_phase_eff;
    if (w_fall) begin
      w_phase_nxt = PH_R;
    end else if (w_accept) begin
      case (w_phase_eff)
        PH_R:    w_phase_nxt = PH_G;
        PH_G:    w_phase_nxt = PH_B;
        default: w_phase_nxt = PH_R;
      endcase
    end
  end

  // Next FIFO occupancy; simultaneous push and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_rise) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
    w_busy_nxt = w_active_nxt | (w_phase_nxt != PH_R) | (w_count_nxt != '0);
  end

  // Download tracking, triplet assembly state and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dl_prev <= 1'b1;
      r_active  <= 1'b0;
      r_phase   <= PH_R;
      r_red     <= '0;
      r_grn     <= '0;
      r_entry   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_dl_prev <= ioctl_download;
      r_active  <= w_active_nxt;
      r_phase   <= w_phase_nxt;
      r_busy    <= w_busy_nxt;
      if (w_accept && (w_phase_eff == PH_R)) begin
        r_red <= ioctl_dout;
      end
      if (w_accept && (w_phase_eff == PH_G)) begin
        r_grn <= ioctl_dout;
      end
      // The entry counter stops at ENTRIES because w_accept is then false.
      if (w_rise) begin
        r_entry <= '0;
      end else if (w_push) begin
        r_entry <= r_entry + 1'b1;
      end
    end
  end

  // FIFO storage; the blue byte is taken straight from the bus.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_red, r_grn, ioctl_dout, 6'(r_entry)};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_rise) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

  // Palette RAM write port; data and index hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_color <= 1'b0;
      r_lc_data    <= '0;
      r_lc_index   <= '0;
    end else begin
      r_load_color <= w_pop;
      if (w_pop) begin
        r_lc_data  <= r_mem[r_rd_ptr][29:6];
        r_lc_index <= r_mem[r_rd_ptr][5:0];
      end
    end
  end

  // Sticky status: loaded after the last index is written, overrun on a
  // byte that ignored backpressure; both cleared by a new download.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pal_loaded <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_rise) begin
        r_pal_loaded <= 1'b0;
      end else if (r_load_color && (r_lc_index == c_LAST_IDX)) begin
        r_pal_loaded <= 1'b1;
      end
      if (w_rise) begin
        r_overrun <= 1'b0;
      end else if (w_overrun_ev) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign ioctl_wait       = w_wait;
  assign load_color       = r_load_color;
  assign load_color_data  = r_lc_data;
  assign load_color_index = r_lc_index;
  assign pal_loaded       = r_pal_loaded;
  assign busy             = r_busy;
  assign overrun          = r_overrun;

endmodule
`default_nettype wire
